// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one combinational ALU between two requesters
// Registered operands toward the ALU, registered result and valid/ready response toward the consumer.
module alu_share_arbiter #(
    parameter int WIDTH   = 32,
    parameter int ALU_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_aluc,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_aluc,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_aluc,
    input  logic [WIDTH-1:0] alu_s,
    input  logic             alu_z,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_s,
    output logic             rsp_z,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    localparam int LAT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t             state_q, state_d;
    logic               rr_ptr_q, rr_ptr_d;
    logic               id_q, id_d;
    logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic [WIDTH-1:0]   alu_a_q, alu_a_d;
    logic [WIDTH-1:0]   alu_b_q, alu_b_d;
    logic [3:0]         alu_aluc_q, alu_aluc_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   rsp_s_q, rsp_s_d;
    logic               rsp_z_q, rsp_z_d;
    logic [CNT_W-1:0]   op_count_q, op_count_d;
    logic               grant;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= 1'b0;
            id_q        <= 1'b0;
            lat_cnt_q   <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_aluc_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_s_q     <= '0;
            rsp_z_q     <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            lat_cnt_q   <= lat_cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_aluc_q  <= alu_aluc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_s_q     <= rsp_s_d;
            rsp_z_q     <= rsp_z_d;
            op_count_q  <= op_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        lat_cnt_d   = lat_cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_aluc_d  = alu_aluc_q;
        rsp_valid_d = rsp_valid_q;
        rsp_s_d     = rsp_s_q;
        rsp_z_d     = rsp_z_q;
        op_count_d  = op_count_q;

        // A lone requester wins outright; contention goes to the round-robin pointer.
        grant = (req0_valid & req1_valid) ? rr_ptr_q : req1_valid;
        // Gated by clrn so every output reads 0 while reset is held.
        req0_ready = clrn & (state_q == S_IDLE) & req0_valid & ~grant;
        req1_ready = clrn & (state_q == S_IDLE) & req1_valid & grant;

        case (state_q)
            S_IDLE: begin
                if (req0_ready | req1_ready) begin
                    alu_a_d    = grant ? req1_a : req0_a;
                    alu_b_d    = grant ? req1_b : req0_b;
                    alu_aluc_d = grant ? req1_aluc : req0_aluc;
                    id_d       = grant;
                    lat_cnt_d  = LAT_W'(ALU_LAT - 1);
                    state_d    = S_EXEC;
                end
            end
            S_EXEC: begin
                if (lat_cnt_q != '0) begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end else begin
                    rsp_s_d     = alu_s;
                    rsp_z_d     = alu_z;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + 1'b1;
                    rr_ptr_d    = ~id_q;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_aluc  = alu_aluc_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_s     = rsp_s_q;
    assign rsp_z     = rsp_z_q;
    assign busy      = (state_q != S_IDLE);
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - self-checking bench for alu_share_arbiter
// Two instances (ALU_LAT=1/CNT_W=16 and ALU_LAT=3/CNT_W=4) share stimulus; sel picks the active one.
module tb_alu_share_arbiter;

    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd4, OP_SLL = 4'd3, OP_SRA = 4'd15, OP_HAMD = 4'd8;

    logic        clk = 1'b0;
    logic        clrn;
    logic        sel;
    logic        v0, v1, rsp_ready;
    logic [31:0] a0, b0, a1, b1;
    logic [3:0]  c0, c1;

    logic        f_rdy0, f_rdy1, f_rv, f_rid, f_rz, f_busy, f_alu_z;
    logic [31:0] f_alu_a, f_alu_b, f_alu_s, f_rs;
    logic [3:0]  f_alu_c;
    logic [15:0] f_cnt;
    logic        s_rdy0, s_rdy1, s_rv, s_rid, s_rz, s_busy, s_alu_z;
    logic [31:0] s_alu_a, s_alu_b, s_alu_s, s_rs;
    logic [3:0]  s_alu_c;
    logic [3:0]  s_cnt;

    always #5 clk = ~clk;

    function automatic logic [32:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        logic [31:0] s;
        case (c)
            4'd0:  s = a + b;
            4'd4:  s = a - b;
            4'd1:  s = a & b;
            4'd5:  s = a | b;
            4'd2:  s = a ^ b;
            4'd6:  s = {b[15:0], 16'h0};
            4'd8:  s = 32'($countones(a ^ b));
            4'd3:  s = b << a[4:0];
            4'd7:  s = b >> a[4:0];
            4'd15: s = $unsigned($signed(b) >>> a[4:0]);
            default: s = 32'h0;
        endcase
        return {(s == 32'h0), s};
    endfunction

    assign {f_alu_z, f_alu_s} = ref_alu(f_alu_a, f_alu_b, f_alu_c);
    assign {s_alu_z, s_alu_s} = ref_alu(s_alu_a, s_alu_b, s_alu_c);

    alu_share_arbiter #(.WIDTH(32), .ALU_LAT(1), .CNT_W(16)) u_fast (
        .clk(clk), .clrn(clrn),
        .req0_valid(v0 & ~sel), .req0_ready(f_rdy0), .req0_a(a0), .req0_b(b0), .req0_aluc(c0),
        .req1_valid(v1 & ~sel), .req1_ready(f_rdy1), .req1_a(a1), .req1_b(b1), .req1_aluc(c1),
        .alu_a(f_alu_a), .alu_b(f_alu_b), .alu_aluc(f_alu_c), .alu_s(f_alu_s), .alu_z(f_alu_z),
        .rsp_valid(f_rv), .rsp_ready(rsp_ready), .rsp_id(f_rid), .rsp_s(f_rs), .rsp_z(f_rz),
        .busy(f_busy), .op_count(f_cnt)
    );

    alu_share_arbiter #(.WIDTH(32), .ALU_LAT(3), .CNT_W(4)) u_slow (
        .clk(clk), .clrn(clrn),
        .req0_valid(v0 & sel), .req0_ready(s_rdy0), .req0_a(a0), .req0_b(b0), .req0_aluc(c0),
        .req1_valid(v1 & sel), .req1_ready(s_rdy1), .req1_a(a1), .req1_b(b1), .req1_aluc(c1),
        .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_aluc(s_alu_c), .alu_s(s_alu_s), .alu_z(s_alu_z),
        .rsp_valid(s_rv), .rsp_ready(rsp_ready), .rsp_id(s_rid), .rsp_s(s_rs), .rsp_z(s_rz),
        .busy(s_busy), .op_count(s_cnt)
    );

    wire        o_rdy0 = sel ? s_rdy0 : f_rdy0;
    wire        o_rdy1 = sel ? s_rdy1 : f_rdy1;
    wire        o_rv   = sel ? s_rv : f_rv;
    wire        o_rid  = sel ? s_rid : f_rid;
    wire        o_rz   = sel ? s_rz : f_rz;
    wire        o_busy = sel ? s_busy : f_busy;
    wire [31:0] o_rs   = sel ? s_rs : f_rs;
    wire [31:0] o_aa   = sel ? s_alu_a : f_alu_a;
    wire [31:0] o_ab   = sel ? s_alu_b : f_alu_b;
    wire [3:0]  o_ac   = sel ? s_alu_c : f_alu_c;
    wire [15:0] o_cnt  = sel ? {12'h0, s_cnt} : f_cnt;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: one operation in flight, aged in cycles since its accept edge.
    logic        m_busy, m_id, m_pref, m_rz;
    int          m_age, m_cnt, hs_total;
    logic [31:0] m_a, m_b, m_rs;
    logic [3:0]  m_c;
    int          acc_log[$];

    task automatic model_reset();
        m_busy = 0; m_id = 0; m_pref = 0; m_rz = 0; m_age = 0; m_cnt = 0;
        m_a = 0; m_b = 0; m_c = 0; m_rs = 0;
    endtask

    task automatic step();
        logic [32:0] r;
        logic        g, e0, e1;
        int          lat, cmod;
        lat  = sel ? 3 : 1;
        cmod = sel ? 16 : 65536;
        #1;
        if (!clrn) begin
            chk("rst_rdy0", 32'(o_rdy0), 0);
            chk("rst_rdy1", 32'(o_rdy1), 0);
            chk("rst_alu_a", o_aa, 0);
            chk("rst_alu_b", o_ab, 0);
            chk("rst_alu_c", 32'(o_ac), 0);
            chk("rst_rv", 32'(o_rv), 0);
            chk("rst_rid", 32'(o_rid), 0);
            chk("rst_rs", o_rs, 0);
            chk("rst_rz", 32'(o_rz), 0);
            chk("rst_busy", 32'(o_busy), 0);
            chk("rst_cnt", 32'(o_cnt), 0);
            model_reset();
        end else begin
            r  = ref_alu(m_a, m_b, m_c);
            g  = (v0 && v1) ? m_pref : v1;
            e0 = !m_busy && v0 && !g;
            e1 = !m_busy && v1 && g;
            chk("rdy0", 32'(o_rdy0), 32'(e0));
            chk("rdy1", 32'(o_rdy1), 32'(e1));
            chk("busy", 32'(o_busy), 32'(m_busy));
            chk("alu_a", o_aa, m_a);
            chk("alu_b", o_ab, m_b);
            chk("alu_c", 32'(o_ac), 32'(m_c));
            chk("cnt", 32'(o_cnt), 32'(m_cnt));
            chk("rsp_valid", 32'(o_rv), 32'(m_busy && m_age >= lat));
            if (m_busy && m_age >= lat) begin
                chk("rsp_s", o_rs, r[31:0]);
                chk("rsp_z", 32'(o_rz), 32'(r[32]));
                chk("rsp_id", 32'(o_rid), 32'(m_id));
            end else begin
                chk("rsp_s_hold", o_rs, m_rs);
                chk("rsp_z_hold", 32'(o_rz), 32'(m_rz));
            end
            if (!m_busy) begin
                if (e0 || e1) begin
                    m_busy = 1; m_age = 0; m_id = e1;
                    m_a = e1 ? a1 : a0;
                    m_b = e1 ? b1 : b0;
                    m_c = e1 ? c1 : c0;
                    acc_log.push_back(int'(e1));
                end
            end else if (m_age >= lat) begin
                if (rsp_ready) begin
                    m_busy = 0;
                    m_cnt  = (m_cnt + 1) % cmod;
                    m_pref = ~m_id;
                    m_rs   = r[31:0];
                    m_rz   = r[32];
                    hs_total++;
                end
            end else begin
                m_age++;
            end
        end
        @(negedge clk);
        #2;
    endtask

    task automatic pulse_reset();
        clrn = 1'b0;
        step();
        clrn = 1'b1;
    endtask

    initial begin
        int n, base;
        clrn = 0; sel = 0; v0 = 0; v1 = 0; rsp_ready = 0;
        a0 = 0; b0 = 0; c0 = 0; a1 = 0; b1 = 0; c1 = 0;
        hs_total = 0;
        model_reset();
        @(negedge clk);
        #2;

        // Reset with a pending request, then ADD 5+7 on the fast instance.
        v0 = 1; a0 = 5; b0 = 7; c0 = OP_ADD; rsp_ready = 1;
        step();
        step();
        clrn = 1;
        #1 chk("t1_ready_first", 32'(o_rdy0), 1);
        step();
        v0 = 0;
        chk("t2_not_yet", 32'(o_rv), 0);
        step();
        chk("t2_rv", 32'(o_rv), 1);
        chk("t2_rs", o_rs, 12);
        chk("t2_rz", 32'(o_rz), 0);
        chk("t2_rid", 32'(o_rid), 0);
        step();
        chk("t2_cnt", 32'(o_cnt), 1);

        // Contention: both requesters hold valid for 8 operations.
        pulse_reset();
        acc_log.delete();
        v0 = 1; a0 = 9; b0 = 9; c0 = OP_SUB;
        v1 = 1; a1 = 32'hF0F0_F0F0; b1 = 0; c1 = OP_HAMD;
        base = hs_total; n = 0;
        while (hs_total - base < 8 && n < 200) begin
            #1;
            if (o_rv && o_rid == 1'b0) chk("t3_sub_z", 32'(o_rz), 1);
            if (o_rv && o_rid == 1'b1) chk("t3_hamd_s", o_rs, 16);
            #0 step();
            n++;
        end
        if (n >= 200) chk("t3_timeout", 0, 1);
        v0 = 0; v1 = 0;
        for (int i = 0; i < 8 && i < acc_log.size(); i++) chk("t3_grant_order", 32'(acc_log[i]), 32'(i % 2));

        // Back-pressure on SRA while both requesters stay valid.
        pulse_reset();
        v0 = 1; a0 = 4; b0 = 32'h8000_0000; c0 = OP_SRA; rsp_ready = 0;
        step();
        v1 = 1; a1 = 1; b1 = 2; c1 = OP_ADD;
        n = 0;
        while (!o_rv && n < 20) begin step(); n++; end
        if (n >= 20) chk("t4_timeout", 0, 1);
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("t4_rs_held", o_rs, 32'hF800_0000);
            chk("t4_no_rdy", 32'({o_rdy0, o_rdy1}), 0);
            step();
        end
        rsp_ready = 1;
        step();
        v0 = 0; v1 = 0;
        step(); step(); step();

        // Slow instance: SLL with three EXEC cycles.
        sel = 1;
        pulse_reset();
        v0 = 1; a0 = 4; b0 = 1; c0 = OP_SLL; rsp_ready = 1;
        step();
        v0 = 0;
        for (int i = 0; i < 3; i++) begin
            chk("t5_exec_rv", 32'(o_rv), 0);
            chk("t5_exec_alu_a", o_aa, 4);
            step();
        end
        chk("t5_rv", 32'(o_rv), 1);
        chk("t5_rs", o_rs, 16);
        step();

        // Reset in EXEC, then in RESP: response discarded, counter stays 0.
        pulse_reset();
        v0 = 1; a0 = 3; b0 = 4; c0 = OP_ADD; rsp_ready = 0;
        step();
        v0 = 0;
        step();
        pulse_reset();
        chk("t6_exec_cnt", 32'(o_cnt), 0);
        chk("t6_exec_rv", 32'(o_rv), 0);
        v0 = 1;
        step();
        v0 = 0;
        n = 0;
        while (!o_rv && n < 20) begin step(); n++; end
        if (n >= 20) chk("t6_timeout", 0, 1);
        pulse_reset();
        chk("t6_resp_cnt", 32'(o_cnt), 0);
        chk("t6_resp_rv", 32'(o_rv), 0);

        // 17 operations on the 4-bit counter wrap it to 1.
        v0 = 1; v1 = 1; rsp_ready = 1;
        base = hs_total; n = 0;
        while (hs_total - base < 17 && n < 400) begin step(); n++; end
        if (n >= 400) chk("t6_wrap_timeout", 0, 1);
        v0 = 0; v1 = 0;
        chk("t6_wrap", 32'(o_cnt), 1);

        // Randomized traffic on both instances with occasional resets.
        for (int ph = 0; ph < 2; ph++) begin
            sel = ph[0];
            pulse_reset();
            for (int cyc = 0; cyc < 1500; cyc++) begin
                v0 = ($urandom_range(0, 2) != 0);
                v1 = ($urandom_range(0, 2) != 0);
                a0 = ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 40);
                b0 = $urandom;
                c0 = 4'($urandom_range(0, 15));
                a1 = ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 40);
                b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
                c1 = 4'($urandom_range(0, 15));
                rsp_ready = ($urandom_range(0, 9) < 7);
                clrn = ($urandom_range(0, 149) != 0);
                step();
                clrn = 1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
